// File: rtl/pc_pkg.sv
// Shared PC types and defaults for the fetch path.
// PC_LOAD_EN (optional) enables the jump/branch load port.
package pc_pkg;

   localparam int          PC_WIDTH     = 16;
   localparam int          PC_STEP      = 2;
   localparam logic [15:0] PC_RESET_VAL = 16'h0000;

   typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/pc_and_adder_if.sv
// Fetch-side PC bus: write enable in, current PC out.
// PC_LOAD_EN adds pcLoad/loadVal for jumps and branches.
interface pc_and_adder_if
   import pc_pkg::*;
#(
   parameter int WIDTH = PC_WIDTH
);

   logic             regWrite;
   logic [WIDTH-1:0] newPC;
`ifdef PC_LOAD_EN
   logic             pcLoad;
   logic [WIDTH-1:0] loadVal;

   modport master (
      output regWrite,
      output pcLoad,
      output loadVal,
      input  newPC
   );

   modport slave (
      input  regWrite,
      input  pcLoad,
      input  loadVal,
      output newPC
   );
`else
   modport master (
      output regWrite,
      input  newPC
   );

   modport slave (
      input  regWrite,
      output newPC
   );
`endif

endinterface

// File: rtl/pc_adder.sv
// Constant-step incrementer, modulo 2^WIDTH.
// Used by pc_and_adder; independent of PC_LOAD_EN.
module pc_adder
   import pc_pkg::*;
#(
   parameter int WIDTH = PC_WIDTH,
   parameter int STEP  = PC_STEP
) (
   input  logic [WIDTH-1:0] a_i,
   output logic [WIDTH-1:0] sum_o
);

   // Carry out of the top bit is intentionally dropped.
   assign sum_o = a_i + WIDTH'(STEP);

endmodule

// File: rtl/pc_and_adder.sv
// Program counter with fixed-step advance for instruction fetch.
// PC_LOAD_EN adds a word-aligned load with priority over regWrite.
module pc_and_adder
   import pc_pkg::*;
#(
   parameter int             WIDTH     = PC_WIDTH,
   parameter int             STEP      = PC_STEP,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PC_RESET_VAL)
) (
   input logic             clk,
   input logic             reset,
   pc_and_adder_if.slave   bus
);

   if ((STEP <= 0) ||
       (64'(STEP) >= (64'd1 << WIDTH)) ||
       ((64'(RESET_VAL) % 64'(STEP)) != 64'd0)) begin : g_bad_cfg
      $fatal(1, "pc_and_adder: bad STEP/RESET_VAL");
   end

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] pc_inc;

   pc_adder #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_adder (
      .a_i   (pc_q),
      .sum_o (pc_inc)
   );

   always_comb begin
      pc_d = pc_q;
      if (reset) begin
         pc_d = RESET_VAL;
`ifdef PC_LOAD_EN
      end else if (bus.pcLoad) begin
         pc_d = bus.loadVal &
                ~{{(WIDTH-1){1'b0}}, 1'b1};
`endif
      end else if (bus.regWrite) begin
         pc_d = pc_inc;
      end
   end

   always_ff @(posedge clk) begin
      pc_q <= pc_d;
   end

   assign bus.newPC = pc_q;

endmodule

// File: tb/tb_pc_and_adder.sv
// Directed self-checking bench for pc_and_adder.
// Covers both builds; PC_LOAD_EN adds load/priority vectors.
module tb_pc_and_adder;
   import pc_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   passes;

   pc_and_adder_if #(.WIDTH(PC_WIDTH)) bus ();

   pc_and_adder #(
      .WIDTH     (PC_WIDTH),
      .STEP      (PC_STEP),
      .RESET_VAL (PC_RESET_VAL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input pc_t exp);
      checks++;
      assert (bus.newPC === exp) passes++;
      else $error("FAIL %s: newPC=%h expected=%h",
                  tag, bus.newPC, exp);
   endtask

   initial begin
      checks       = 0;
      passes       = 0;
      reset        = 1'b1;
      bus.regWrite = 1'b1;
`ifdef PC_LOAD_EN
      bus.pcLoad  = 1'b0;
      bus.loadVal = '0;
`endif
      #2;

      // reset wins over regWrite
      step();
      check("reset", 16'h0000);

      // single increment then hold
      reset = 1'b0;
      step();
      check("inc1", 16'h0002);
      bus.regWrite = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold", 16'h0002);
      end

      // alternating enable
      reset = 1'b1;
      step();
      check("reset2", 16'h0000);
      reset = 1'b0;
      bus.regWrite = 1'b1; step(); check("alt0", 16'h0002);
      bus.regWrite = 1'b0; step(); check("alt1", 16'h0002);
      bus.regWrite = 1'b1; step(); check("alt2", 16'h0004);
      bus.regWrite = 1'b0; step(); check("alt3", 16'h0004);

      // get near the top, then burst through the wrap
`ifdef PC_LOAD_EN
      bus.pcLoad  = 1'b1;
      bus.loadVal = 16'hFFFC;
      step();
      bus.pcLoad  = 1'b0;
`else
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.regWrite = 1'b1;
      for (int i = 0; i < 32766; i++) step();
      bus.regWrite = 1'b0;
      step();
`endif
      check("top", 16'hFFFC);
      bus.regWrite = 1'b1;
      step(); check("wrap0", 16'hFFFE);
      step(); check("wrap1", 16'h0000);
      step(); check("wrap2", 16'h0002);

      // reset mid-run at PC=8
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("at8", 16'h0008);
      reset = 1'b1;
      step();
      check("midrst", 16'h0000);
      reset = 1'b0;
      step();
      check("resume", 16'h0002);

`ifdef PC_LOAD_EN
      // load beats regWrite, LSB forced low
      bus.pcLoad  = 1'b1;
      bus.loadVal = 16'h1235;
      step();
      check("load", 16'h1234);
      reset = 1'b1;
      step();
      check("rst_over_load", 16'h0000);
      reset = 1'b0;
      bus.pcLoad = 1'b0;
      step();
      check("after_load", 16'h0002);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/pc_and_adder.md
Name: pc_and_adder

Overview:
- Program counter register with built-in fixed-step incrementer for the stack processor's fetch path.
- Holds the current instruction address and presents it on newPC.
- Advances by one instruction (2 bytes) on each clock edge where regWrite is asserted.
- Instruction fetch addresses memory from newPC; control unit drives regWrite once per instruction.

Parameters:
- WIDTH, 16, PC/address width in bits.
- STEP, 2, byte increment per write (16-bit instructions).
- RESET_VAL, 16'h0000, PC value loaded by reset; must be a multiple of STEP.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- regWrite  input  1  PC write enable; when high, PC advances by STEP at the next rising edge.
- newPC  output  WIDTH  current PC value, driven directly from the PC register (no combinational path from inputs).

Behaviour:
- Single register pc[WIDTH-1:0]; newPC = pc.
- Rising edge of clk, priority order:
  - reset=1: pc <= RESET_VAL, regardless of regWrite.
  - else regWrite=1: pc <= pc + STEP.
  - else: pc holds.
- Latency: newPC reflects an increment one edge after regWrite is sampled high. No handshake.
- Arithmetic: unsigned, modulo 2^WIDTH, carry discarded. With defaults, 16'hFFFE + 2 -> 16'h0000. No overflow flag.
- regWrite held high for N edges: pc advances by N*STEP.
- Reset asserted mid-sequence overrides any pending increment on that edge.
- Reset releases on the next edge where reset=0; increments resume from RESET_VAL.
- Power-up value is undefined until the first reset edge. A bench must apply reset before checking.
- Elaboration check: if RESET_VAL % STEP != 0, or STEP >= 2^WIDTH, raise a fatal/elaboration error.
- The LSB stays 0 for all reachable values when STEP=2 and RESET_VAL is even.

Optional Feature:
- Macro: PC_LOAD_EN.
- Defined:
  - Adds ports pcLoad (input, 1) and loadVal (input, WIDTH) for jumps and branches.
  - Priority on each rising edge: reset > pcLoad > regWrite > hold.
  - pcLoad=1 sets pc <= loadVal with LSB forced to 0 (word alignment), in the same single edge.
- Undefined: ports are absent and behaviour is exactly as above.

Decomposition:
- Shared package pc_pkg holds:
  - PC_WIDTH = 16
  - PC_STEP = 2
  - PC_RESET_VAL = 16'h0000
  - typedef pc_t (logic [PC_WIDTH-1:0])
- One natural sub-module: pc_adder, a combinational WIDTH-bit adder of a constant STEP with carry discarded, instantiated by pc_and_adder.
- The register and next-state mux stay in the top module.

Test Plan:
- Reset: hold reset=1 for one edge with regWrite=1 -> newPC=16'h0000 after the edge.
- Single increment: after reset, regWrite=1 for one edge, then 0 -> newPC=2, and stays 2 for 3 further edges.
- Alternating enable: regWrite toggles 1,0,1,0 over 4 edges from 0 -> newPC sequence 2,2,4,4. Never increments on a regWrite=0 edge.
- Burst and wrap: load near the top via reset-then-burst (or loadVal=16'hFFFC if PC_LOAD_EN), regWrite=1 for 3 edges -> 16'hFFFE, 16'h0000, 16'h0002.
- Reset mid-run: at PC=16'h0008 with regWrite=1, assert reset for one edge -> newPC=0. Next edge with regWrite=1 -> 2.
- (PC_LOAD_EN) Priority: pcLoad=1, loadVal=16'h1235, regWrite=1 -> newPC=16'h1234. Same stimulus with reset=1 -> 16'h0000.
